// File: rtl/conv_pkg.sv
// Shared fixed-point types and helpers for the conv layer (window MAC, pool stage).
package conv_pkg;
  localparam int PIX_W             = 16;
  localparam int FRAC_BITS_DEFAULT = 8;
  localparam int KERNEL_DEFAULT    = 3;
  localparam int CHANNELS_DEFAULT  = 4;
  // Smallest accumulator that cannot overflow over a full channel sweep.
  localparam int ACC_WIDTH_MIN = 2*PIX_W + $clog2(KERNEL_DEFAULT*KERNEL_DEFAULT*CHANNELS_DEFAULT);
  localparam int ACC_WIDTH_DEFAULT = 40;

  typedef logic signed [PIX_W-1:0]             pixel_t;
  typedef logic signed [PIX_W-1:0]             weight_t;
  typedef logic signed [2*PIX_W-1:0]           product_t;
  typedef logic signed [ACC_WIDTH_DEFAULT-1:0] acc_t;

  // Clamp a wide signed value into the signed range of a w-bit word; caller truncates.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w-1)) - 64'sd1;
    lo = -(64'sd1 <<< (w-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/conv_window_mac_if.sv
// Window-in / pixel-out bus between the line-buffer register stage and the MAC.
interface conv_window_mac_if #(parameter int K = 3, parameter int DW = 16, parameter int CH_W = 2);
  logic                                 start_mac;
  logic signed [K-1:0][K-1:0][DW-1:0]   window_in;
  logic signed [K-1:0][K-1:0][DW-1:0]   weight_in;
  logic        [CH_W-1:0]               channel_in;
  logic signed [DW-1:0]                 bias;
  logic signed [DW-1:0]                 pixel_out;
  logic                                 pixel_valid;
  logic                                 seq_err;

  modport master (output start_mac, window_in, weight_in, channel_in, bias,
                  input  pixel_out, pixel_valid, seq_err);
  modport slave  (input  start_mac, window_in, weight_in, channel_in, bias,
                  output pixel_out, pixel_valid, seq_err);
endinterface

// File: rtl/mac_adder_tree.sv
// Registered signed sum of N products, widened by clog2(N) so it cannot overflow.
module mac_adder_tree #(
  parameter int N    = 9,
  parameter int IN_W = 32,
  localparam int OUT_W = IN_W + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0][IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] sum
);
  logic signed [OUT_W-1:0] s;

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) s = s + OUT_W'($signed(din[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) sum <= '0;
    else     sum <= s;
  end
endmodule

// File: rtl/conv_window_mac.sv
// KxK window MAC: products (S1), adder tree (S2), channel accumulate + bias/scale/saturate (S3).
// Optional CONV_MAC_RELU_EN clamps negative saturated results to 0.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int IN_CHANNELS = CHANNELS_DEFAULT,
  parameter int KERNEL_SIZE = KERNEL_DEFAULT,
  parameter int DATA_WIDTH  = PIX_W,
  parameter int FRAC_BITS   = FRAC_BITS_DEFAULT,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  conv_window_mac_if.slave  bus
);
  localparam int NP     = KERNEL_SIZE*KERNEL_SIZE;
  localparam int PW     = 2*DATA_WIDTH;
  localparam int SW     = PW + $clog2(NP);
  localparam int CW     = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int TW     = ACC_WIDTH + 1;
  localparam int STAGES = 2;

  logic [STAGES:0]          vld_pipe;
  logic [NP-1:0][PW-1:0]    prod;
  logic [CW-1:0]            tag1, tag2, exp_ch;
  logic signed [DATA_WIDTH-1:0] bias1, bias2;
  logic signed [SW-1:0]     sum2;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, sum_ext;
  logic signed [TW-1:0]     total, scaled;
  logic signed [63:0]       sat;
  logic signed [DATA_WIDTH-1:0] res;
  logic                     tag_ok, is_last;

  assign vld_pipe[0] = bus.start_mac;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      prod  <= '0;
      tag1  <= '0;
      tag2  <= '0;
      bias1 <= '0;
      bias2 <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      tag2  <= tag1;
      bias2 <= bias1;
      if (bus.start_mac) begin
        tag1  <= bus.channel_in;
        bias1 <= bus.bias;
        for (int r = 0; r < KERNEL_SIZE; r++)
          for (int c = 0; c < KERNEL_SIZE; c++)
            prod[r*KERNEL_SIZE+c] <= PW'($signed(bus.window_in[r][c])) *
                                     PW'($signed(bus.weight_in[r][c]));
      end
    end
  end

  mac_adder_tree #(.N(NP), .IN_W(PW)) u_tree (
    .clk (clk),
    .rst (rst),
    .din (prod),
    .sum (sum2)
  );

  // Tags past the channel count only exist for non-power-of-2 IN_CHANNELS.
  assign tag_ok  = {1'b0, tag2} < (CW+1)'(IN_CHANNELS);
  assign is_last = tag2 == CW'(IN_CHANNELS-1);

  always_comb begin
    sum_ext  = ACC_WIDTH'(sum2);
    acc_next = (tag2 == '0) ? sum_ext : acc + sum_ext;
    total    = TW'(acc_next) + (TW'(bias2) <<< FRAC_BITS);
    scaled   = total >>> FRAC_BITS;
    sat      = sat_to_width(64'(scaled), DATA_WIDTH);
    res      = DATA_WIDTH'(sat);
`ifdef CONV_MAC_RELU_EN
    if (res < 0) res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      exp_ch          <= '0;
      bus.seq_err     <= 1'b0;
      bus.pixel_out   <= '0;
      bus.pixel_valid <= 1'b0;
    end else begin
      bus.pixel_valid <= 1'b0;
      if (vld_pipe[STAGES]) begin
        if (!tag_ok) begin
          bus.seq_err <= 1'b1;
        end else begin
          acc <= acc_next;
          // Tag 0 is always a legal sweep start; any other tag must follow on.
          if (tag2 != '0 && tag2 != exp_ch) bus.seq_err <= 1'b1;
          exp_ch <= is_last ? '0 : tag2 + 1'b1;
          if (is_last) begin
            bus.pixel_out   <= res;
            bus.pixel_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: directed table, hand sequences, random vs behavioural model.
module tb_conv_window_mac;
  localparam int K = 3, DW = 16, CH = 4, CW = 2, FB = 8;
  localparam int NO_ERR = 32'h7fffffff;

  typedef logic signed [K-1:0][K-1:0][DW-1:0] win_t;
  typedef struct { int due; int pix; } exp_t;
  typedef struct { string name; int win; int wt; int bias; int gap; int nsw; bit alt; int exp0; int exp1; } row_t;

  logic clk, rst;
  conv_window_mac_if #(.K(K), .DW(DW), .CH_W(CW)) bus();

  conv_window_mac #(.IN_CHANNELS(CH), .KERNEL_SIZE(K), .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     cyc, checks, failures;
  exp_t   q[$];
  int     got_q[$];
  int     last_pix, err_due, m_exp;
  longint m_acc;
  row_t   rows[5];

  function automatic int relu(input int x);
`ifdef CONV_MAC_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic win_t fill(input int v);
    win_t f;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) f[r][c] = 16'(v);
    return f;
  endfunction

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // Spec-level model: dot product per window, channel accumulation, fixed-point rescale.
  task automatic model_accept(input int tag, input win_t w, input win_t k, input int b);
    int e;
    longint dot, total, sh;
    int pix;
    e = cyc + 1;
    if (tag >= CH) begin
      if (e + 2 < err_due) err_due = e + 2;
      return;
    end
    if (tag != 0 && tag != m_exp && e + 2 < err_due) err_due = e + 2;
    m_exp = (tag == CH-1) ? 0 : tag + 1;
    dot = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        dot += longint'($signed(w[r][c])) * longint'($signed(k[r][c]));
    m_acc = (tag == 0) ? dot : m_acc + dot;
    if (tag == CH-1) begin
      total = m_acc + longint'(b) * (64'sd1 <<< FB);
      sh = total >>> FB;
      if (sh > 32767) pix = 32767;
      else if (sh < -32768) pix = -32768;
      else pix = int'(sh);
      q.push_back('{due: e + 2, pix: relu(pix)});
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    if (ev) begin
      last_pix = q[0].pix;
      void'(q.pop_front());
    end
    cmp("pixel_valid", int'(bus.pixel_valid), int'(ev));
    cmp("pixel_out", int'(bus.pixel_out), last_pix);
    cmp("seq_err", int'(bus.seq_err), int'(err_due <= cyc));
    if (bus.pixel_valid) got_q.push_back(int'(bus.pixel_out));
  endtask

  task automatic step(input bit v, input int tag, input win_t w, input win_t k, input int b, input bit r);
    rst            = r;
    bus.start_mac  = v & ~r;
    bus.channel_in = CW'(tag);
    bus.window_in  = w;
    bus.weight_in  = k;
    bus.bias       = 16'(b);
    if (r) begin
      q.delete();
      last_pix = 0;
      err_due  = NO_ERR;
      m_acc    = 0;
      m_exp    = 0;
    end else if (v) begin
      model_accept(tag, w, k, b);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, fill(0), fill(0), 0, 1'b0);
  endtask

  initial begin
    int nt, tag, b;
    bit v;
    win_t w, k;
    cyc = 0; checks = 0; failures = 0;
    last_pix = 0; err_due = NO_ERR; m_acc = 0; m_exp = 0;

    rows[0] = '{"basic",    256,    256,   0,   0, 1, 1'b0, 9216,          9216};
    rows[1] = '{"sat_pos",  32767,  32767, 0,   0, 1, 1'b0, 32767,         32767};
    rows[2] = '{"sat_neg",  -32768, 32767, 0,   0, 1, 1'b0, relu(-32768),  relu(-32768)};
    rows[3] = '{"stream",   256,    256,   128, 0, 4, 1'b1, 9344,          relu(-9088)};
    rows[4] = '{"bubbles",  256,    256,   0,   2, 1, 1'b0, 9216,          9216};

    step(1'b0, 0, fill(0), fill(0), 0, 1'b1);
    step(1'b0, 0, fill(0), fill(0), 0, 1'b1);

    for (int ri = 0; ri < 5; ri++) begin
      got_q.delete();
      for (int s = 0; s < rows[ri].nsw; s++) begin
        k = fill((rows[ri].alt && s[0]) ? -rows[ri].wt : rows[ri].wt);
        for (int ch = 0; ch < CH; ch++) begin
          step(1'b1, ch, fill(rows[ri].win), k, rows[ri].bias, 1'b0);
          for (int g = 0; g < rows[ri].gap; g++) step(1'b0, 0, fill(0), fill(0), 0, 1'b0);
        end
      end
      idle(4);
      cmp({rows[ri].name, "_count"}, got_q.size(), rows[ri].nsw);
      for (int i = 0; i < got_q.size(); i++)
        cmp({rows[ri].name, "_pix"}, got_q[i], (rows[ri].alt && i[0]) ? rows[ri].exp1 : rows[ri].exp0);
    end

    // Skipped channel 1: error flags and sticks, sweep still produces ch0+ch2+ch3.
    got_q.delete();
    step(1'b1, 0, fill(256), fill(256), 0, 1'b0);
    step(1'b1, 2, fill(256), fill(256), 0, 1'b0);
    step(1'b1, 3, fill(256), fill(256), 0, 1'b0);
    idle(6);
    cmp("seqerr_count", got_q.size(), 1);
    if (got_q.size() > 0) cmp("seqerr_pix", got_q[0], 6912);
    cmp("seqerr_sticky", int'(bus.seq_err), 1);

    // Reset mid-sweep aborts the partial sweep and clears the error.
    got_q.delete();
    step(1'b1, 0, fill(256), fill(256), 0, 1'b0);
    step(1'b1, 1, fill(256), fill(256), 0, 1'b0);
    step(1'b0, 0, fill(0), fill(0), 0, 1'b1);
    cmp("rst_pix", int'(bus.pixel_out), 0);
    cmp("rst_err", int'(bus.seq_err), 0);
    for (int ch = 0; ch < CH; ch++) step(1'b1, ch, fill(256), fill(256), 0, 1'b0);
    idle(4);
    cmp("rst_count", got_q.size(), 1);
    if (got_q.size() > 0) cmp("rst_next_pix", got_q[0], 9216);
    cmp("rst_err_after", int'(bus.seq_err), 0);

    // Random windows/weights/bias, mostly in-order tags, occasional reset.
    nt = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        step(1'b0, 0, fill(0), fill(0), 0, 1'b1);
        nt = 0;
        continue;
      end
      v = ($urandom_range(0, 3) != 0);
      tag = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, CH-1)) : nt;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          w[r][c] = 16'($urandom);
          k[r][c] = 16'($urandom);
        end
      b = int'($signed(16'($urandom)));
      step(v, tag, w, k, b, 1'b0);
      if (v) nt = (tag == CH-1) ? 0 : tag + 1;
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
